// File: rtl/lif_neuron_if.sv
// ---------------------------------------------------------------------------
// lif_neuron_if
// Bundles the signals between the MAC stage / classifier and one LIF neuron.
//   master : drives sum_in, sum_valid, clear; observes the neuron outputs
//   slave  : the neuron itself
// Signals:
//   sum_in      signed weighted sum from the MAC (SUM_W)
//   sum_valid   one-cycle strobe, sum_in valid this cycle
//   clear       synchronous clear of neuron state
//   spike       spike decision for the consumed sum
//   spike_valid strobe one cycle after each accepted sum_valid
//   v_mem       registered membrane potential (signed, V_W)
//   spike_count saturating spike count (CNT_W)
//   refractory  high while the neuron is refractory
// ---------------------------------------------------------------------------
interface lif_neuron_if #(
    parameter int SUM_W = 21,
    parameter int V_W   = 24,
    parameter int CNT_W = 16
);
    logic signed [SUM_W-1:0] sum_in;
    logic                    sum_valid;
    logic                    clear;
    logic                    spike;
    logic                    spike_valid;
    logic signed [V_W-1:0]   v_mem;
    logic [CNT_W-1:0]        spike_count;
    logic                    refractory;

    modport master (
        output sum_in, sum_valid, clear,
        input  spike, spike_valid, v_mem, spike_count, refractory
    );

    modport slave (
        input  sum_in, sum_valid, clear,
        output spike, spike_valid, v_mem, spike_count, refractory
    );
endinterface

// File: rtl/lif_neuron.sv
// ---------------------------------------------------------------------------
// lif_neuron
// Leaky integrate-and-fire neuron fed by the 25-input spike/weight MAC.
// Each accepted sum leaks the membrane potential by v >>> LEAK_SHIFT, adds the
// sum, saturates, and fires when the result reaches THRESH. After a spike the
// next REFRAC sums are discarded. One spike decision per accepted sum,
// registered, one cycle later. A saturating spike counter feeds the
// output-layer classifier.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    lif_neuron_if.slave (sum_in/sum_valid/clear in; spike,
//          spike_valid, v_mem, spike_count, refractory out)
// ---------------------------------------------------------------------------
module lif_neuron #(
    parameter int SUM_W      = 21,
    parameter int V_W        = 24,
    parameter int THRESH     = 4096,
    parameter int V_RESET    = 0,
    parameter int V_MIN      = -4096,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2,
    parameter int CNT_W      = 16
) (
    input logic         clk,
    input logic         rst_n,
    lif_neuron_if.slave bus
);

    // Two guard bits so v - leak + sum cannot wrap before saturation.
    localparam int WIDE_W = V_W + 2;
    localparam int RC_W   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic signed [V_W-1:0] THRESH_V  = V_W'(THRESH);
    localparam logic signed [V_W-1:0] V_RESET_V = V_W'(V_RESET);
    localparam logic signed [V_W-1:0] V_MIN_V   = V_W'(V_MIN);

    typedef enum logic {
        ST_ACTIVE  = 1'b0,
        ST_REFRACT = 1'b1
    } state_e;

    // Saturate a wide intermediate to the signed V_W range.
    function automatic logic signed [V_W-1:0] sat_v(input logic signed [WIDE_W-1:0] x);
        logic signed [WIDE_W-1:0] vmax;
        logic signed [WIDE_W-1:0] vmin;
        vmax = WIDE_W'({1'b0, {(V_W-1){1'b1}}});
        vmin = ~vmax;
        if (x > vmax)      return vmax[V_W-1:0];
        else if (x < vmin) return vmin[V_W-1:0];
        else               return x[V_W-1:0];
    endfunction

    // Lower clamp of the potential.
    function automatic logic signed [V_W-1:0] clamp_min(input logic signed [V_W-1:0] v);
        return (v < V_MIN_V) ? V_MIN_V : v;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_e                state_q, state_d;
    logic signed [V_W-1:0] v_mem_q, v_mem_d;
    logic [RC_W-1:0]       refr_cnt_q, refr_cnt_d;
    logic [CNT_W-1:0]      spike_count_q, spike_count_d;
    logic                  spike_q, spike_d;
    logic                  spike_valid_q, spike_valid_d;

    logic signed [WIDE_W-1:0] v_ext;
    logic signed [WIDE_W-1:0] leak;
    logic signed [WIDE_W-1:0] sum_ext;
    logic signed [V_W-1:0]    v_next;

    always_comb begin
        state_d       = state_q;
        v_mem_d       = v_mem_q;
        refr_cnt_d    = refr_cnt_q;
        spike_count_d = spike_count_q;
        spike_d       = 1'b0;
        spike_valid_d = 1'b0;

        v_ext   = {{2{v_mem_q[V_W-1]}}, v_mem_q};
        leak    = v_ext >>> LEAK_SHIFT;
        sum_ext = {{(WIDE_W-SUM_W){bus.sum_in[SUM_W-1]}}, bus.sum_in};
        v_next  = sat_v(v_ext - leak + sum_ext);

        if (bus.clear) begin
            // Clear wins over a coincident sum; that sum is dropped silently.
            state_d       = ST_ACTIVE;
            v_mem_d       = '0;
            refr_cnt_d    = '0;
            spike_count_d = '0;
        end else if (bus.sum_valid) begin
            spike_valid_d = 1'b1;
            case (state_q)
                ST_ACTIVE: begin
                    if (v_next >= THRESH_V) begin
                        spike_d       = 1'b1;
                        v_mem_d       = V_RESET_V;
                        spike_count_d = sat_inc(spike_count_q);
                        if (REFRAC > 0) begin
                            refr_cnt_d = RC_W'(REFRAC);
                            state_d    = ST_REFRACT;
                        end else begin
                            refr_cnt_d = '0;
                        end
                    end else begin
                        v_mem_d = clamp_min(v_next);
                    end
                end
                ST_REFRACT: begin
                    // Sum discarded; leave refractory when the count runs out.
                    v_mem_d = V_RESET_V;
                    if (refr_cnt_q <= RC_W'(1)) begin
                        refr_cnt_d = '0;
                        state_d    = ST_ACTIVE;
                    end else begin
                        refr_cnt_d = refr_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACTIVE;
            v_mem_q       <= '0;
            refr_cnt_q    <= '0;
            spike_count_q <= '0;
            spike_q       <= 1'b0;
            spike_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_mem_q       <= v_mem_d;
            refr_cnt_q    <= refr_cnt_d;
            spike_count_q <= spike_count_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
        end
    end

    assign bus.spike       = spike_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.v_mem       = v_mem_q;
    assign bus.spike_count = spike_count_q;
    assign bus.refractory  = (state_q == ST_REFRACT);

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron that sits directly downstream of the 25-input spike/weight MAC stage. Once per timestep it consumes the MAC's 21-bit weighted sum and updates a signed membrane potential. The update applies a shift-based leak, then the threshold check, the spike, the reset and the refractory period. It emits one spike decision per consumed sum and keeps a saturating spike count for output-layer classification.

Parameters:
SUM_W, 21, width of incoming MAC sum (signed two's complement)
V_W, 24, membrane potential width (signed)
THRESH, 4096, firing threshold; fire when V_next >= THRESH
V_RESET, 0, potential loaded after a spike
V_MIN, -4096, lower clamp of potential
LEAK_SHIFT, 4, leak = V >>> LEAK_SHIFT (arithmetic shift, floor)
REFRAC, 2, number of sum_valid events ignored after a spike
CNT_W, 16, spike counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sum_in  input  SUM_W  weighted sum from MAC, signed
sum_valid  input  1  one-cycle strobe: sum_in valid this cycle, one per timestep
clear  input  1  synchronous clear of neuron state between input samples
spike  output  1  spike decision for the consumed sum
spike_valid  output  1  strobe, high one cycle after each accepted sum_valid
v_mem  output  V_W  current membrane potential (registered)
spike_count  output  CNT_W  saturating count of spikes since reset/clear
refractory  output  1  high while state is REFRACT

Behaviour:
- Reset (rst_n=0, async): v_mem=0, spike=0, spike_valid=0, spike_count=0, refr counter=0, refractory=0, state=ACTIVE. Reset is honoured at any point, including mid-refractory.
- FSM states: ACTIVE, REFRACT.
- ACTIVE, sum_valid=1: the block computes the following at V_W+2 bits, signed.
  - leak = v_mem >>> LEAK_SHIFT.
  - V_next = v_mem - leak + sign-extended sum_in.
  - Saturate V_next to the V_W signed range.
  - If V_next >= THRESH: spike=1, v_mem<=V_RESET, refr counter<=REFRAC, spike_count increments (holds at all-ones), state<=REFRACT. If REFRAC=0, state stays ACTIVE.
  - Otherwise: spike=0, v_mem<=max(V_next, V_MIN).
- REFRACT, sum_valid=1: sum_in is discarded, v_mem holds at V_RESET, spike=0, and the refr counter decrements. When the counter reaches 0, state<=ACTIVE; the next sum_valid integrates normally.
- spike_valid=1 on the cycle after every sum_valid, in both states; otherwise 0. spike is valid only with spike_valid and is 0 otherwise.
- Latency: 1 cycle from sum_valid to spike/spike_valid/v_mem update. Back-to-back sum_valid on consecutive cycles is fully supported, with no stall.
- sum_valid=0: all state holds, spike=0, spike_valid=0.
- clear=1: v_mem=0, refr counter=0, spike_count=0, state=ACTIVE, spike=0, spike_valid=0. Clear has priority over a simultaneous sum_valid; that sum is dropped and produces no spike_valid.
- refractory output = (state==REFRACT).

Test Plan:
- Integration to fire: reset, then sum_in=1000 on 5 consecutive sum_valid pulses.
  - Required v_mem sequence: 1000, 1938, 2817, 3641.
  - 5th pulse: spike=1, v_mem=0, spike_count=1, refractory=1.
- Refractory: continue the previous test with 3 more pulses of sum_in=1000.
  - Pulses 6-7: spike=0, v_mem=0; refractory drops after pulse 7.
  - Pulse 8 integrates: v_mem=1000.
- Negative clamp and leak: from v_mem=0, sum_in=-5000 -> v_mem=-4096. Then sum_in=0 -> v_mem=-3840.
- Clear priority: clear=1 and sum_valid=1 with sum_in=5000 in the same cycle.
  - Required: v_mem=0, spike_count=0, spike_valid=0 next cycle.
- Async reset mid-refractory: drop rst_n between clock edges while refractory=1.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, sum_in=4096 -> spike=1 one cycle later.
- Counter saturation: CNT_W=2, sum_in=8000 for 12 pulses, REFRAC=0.
  - Required: a spike on every pulse; spike_count saturates at 3.
